// File: rtl/reti_monitor_if.sv
// Signal bundle between the CPU/decoder side and the RETI monitor.
// The master drives the CPU-side observations and the slave drives the monitor results.
interface reti_monitor_if;
    logic [13:0] irq_acc;
    logic        reti_exec;
    logic [15:0] pc;
    logic        irq_ret;
    logic        ret_all;
    logic [15:0] ret_pc;
    logic [3:0]  depth;
    logic        in_isr;
    logic [2:0]  err;

    modport master (
        output irq_acc, reti_exec, pc,
        input  irq_ret, ret_all, ret_pc, depth, in_isr, err
    );

    modport slave (
        input  irq_acc, reti_exec, pc,
        output irq_ret, ret_all, ret_pc, depth, in_isr, err
    );
endinterface

// File: rtl/reti_monitor.sv
// Tracks interrupt nesting and pulses irq_ret a fixed delay after an accepted RETI.
// It also captures the resumed PC and keeps sticky protocol-error flags.
module reti_monitor #(
    parameter int unsigned RET_DELAY = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    reti_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RET  = 2'd2
    } state_t;

    localparam logic [3:0] DELAY = 4'(RET_DELAY);
    localparam logic [3:0] DEPTH_MAX = 4'd15;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_depth;
    logic [15:0] r_ret_pc;
    logic [2:0]  r_err;

    logic w_acc_nz;
    logic w_idle;
    logic w_accept;
    logic w_unmatched;
    logic w_overlap;
    logic w_depth_inc;
    logic w_depth_dec;

    assign w_acc_nz    = |bus.irq_acc;
    assign w_idle      = (r_state == IDLE);
    assign w_accept    = w_idle && bus.reti_exec && (r_depth != 4'd0);
    assign w_unmatched = w_idle && bus.reti_exec && (r_depth == 4'd0);
    assign w_overlap   = !w_idle && bus.reti_exec;
    // An entry coinciding with an accepted return cancels out, so depth holds.
    assign w_depth_inc = w_acc_nz && !w_accept;
    assign w_depth_dec = w_accept && !w_acc_nz;

    // NOTE: every register, including ret_pc, has a defined reset value because the
    // attestation logic may read it before the first return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_depth  <= 4'd0;
            r_ret_pc <= 16'h0000;
            r_err    <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments so that every branch sees the pre-edge values.
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= WAIT;
                        r_cnt   <= 4'd1;
                    end
                end
                WAIT: begin
                    if (r_cnt == DELAY) begin
                        r_state  <= RET;
                        r_ret_pc <= bus.pc;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                RET: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase

            if (w_depth_inc) begin
                if (r_depth == DEPTH_MAX) begin
                    r_err[1] <= 1'b1;
                end else begin
                    r_depth <= r_depth + 4'd1;
                end
            end else if (w_depth_dec) begin
                r_depth <= r_depth - 4'd1;
            end

            if (w_unmatched) begin
                r_err[0] <= 1'b1;
            end
            if (w_overlap) begin
                r_err[2] <= 1'b1;
            end
        end
    end

    assign bus.irq_ret = (r_state == RET);
    assign bus.ret_all = (r_state == RET) && (r_depth == 4'd0) && !w_acc_nz;
    assign bus.ret_pc  = r_ret_pc;
    assign bus.depth   = r_depth;
    assign bus.in_isr  = (r_depth != 4'd0);
    assign bus.err     = r_err;

endmodule

// File: tb/tb_reti_monitor.sv
// Directed bench for reti_monitor: a cycle-scheduled reference model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_reti_monitor;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reti_monitor_if bus_if ();

    reti_monitor #(.RET_DELAY(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: nesting count, sticky errors, and the cycle at which the
    // pending return must pulse (relative to the last reset release).
    int          m_cyc;
    int          m_depth;
    int          m_ret_cycle;
    logic [2:0]  m_err;
    logic [15:0] m_ret_pc;
    int          irq_cnt;
    int          all_cnt;
    logic        exp_ret;
    logic        exp_all;
    logic        busy;
    logic        accept;
    logic        inc;

    initial begin
        irq_cnt = 0;
        all_cnt = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_irq_ret", 32'(bus_if.irq_ret), 32'd0);
            check("rst_ret_all", 32'(bus_if.ret_all), 32'd0);
            check("rst_depth",   32'(bus_if.depth),   32'd0);
            check("rst_in_isr",  32'(bus_if.in_isr),  32'd0);
            check("rst_err",     32'(bus_if.err),     32'd0);
            check("rst_ret_pc",  32'(bus_if.ret_pc),  32'd0);
            m_cyc       = 0;
            m_depth     = 0;
            m_ret_cycle = -1;
            m_err       = 3'b000;
            m_ret_pc    = 16'h0000;
        end else begin
            exp_ret = (m_ret_cycle == m_cyc);
            exp_all = exp_ret && (m_depth == 0) && (bus_if.irq_acc == 14'h0);
            check("irq_ret", 32'(bus_if.irq_ret), 32'(exp_ret));
            check("ret_all", 32'(bus_if.ret_all), 32'(exp_all));
            check("depth",   32'(bus_if.depth),   32'(m_depth));
            check("in_isr",  32'(bus_if.in_isr),  32'(m_depth != 0));
            check("err",     32'(bus_if.err),     32'(m_err));
            check("ret_pc",  32'(bus_if.ret_pc),  32'(m_ret_pc));
            if (bus_if.irq_ret) irq_cnt++;
            if (bus_if.ret_all) all_cnt++;

            busy   = (m_ret_cycle != -1);
            accept = 1'b0;
            inc    = (bus_if.irq_acc != 14'h0);
            if (busy && m_cyc == m_ret_cycle - 1) m_ret_pc = bus_if.pc;
            if (busy && m_cyc == m_ret_cycle) m_ret_cycle = -1;
            if (bus_if.reti_exec) begin
                if (busy) m_err[2] = 1'b1;
                else if (m_depth == 0) m_err[0] = 1'b1;
                else begin
                    accept      = 1'b1;
                    m_ret_cycle = m_cyc + D + 1;
                end
            end
            if (accept && !inc) m_depth--;
            else if (inc && !accept) begin
                if (m_depth == 15) m_err[1] = 1'b1;
                else m_depth++;
            end
            m_cyc++;
        end
    end

    task automatic drive(input logic [13:0] a, input logic r, input logic [15:0] p);
        bus_if.irq_acc   = a;
        bus_if.reti_exec = r;
        bus_if.pc        = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(14'h0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        bus_if.irq_acc   = 14'h0;
        bus_if.reti_exec = 1'b0;
        bus_if.pc        = 16'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int irq0;
    int all0;

    initial begin
        do_reset();

        // Single nest: entry at cycle 0, RETI at cycle 10, pc E100 in cycle 14.
        irq0 = irq_cnt; all0 = all_cnt;
        drive(14'h0004, 1'b0, 16'h0);
        check("t1_depth_c1", 32'(bus_if.depth), 32'd1);
        idle(9);
        drive(14'h0, 1'b1, 16'h0);
        check("t1_depth_c11", 32'(bus_if.depth), 32'd0);
        idle(3);
        check("t1_no_ret_c14", 32'(bus_if.irq_ret), 32'd0);
        drive(14'h0, 1'b0, 16'hE100);
        check("t1_ret_c15", 32'(bus_if.irq_ret), 32'd1);
        idle(1);
        check("t1_ret_off_c16", 32'(bus_if.irq_ret), 32'd0);
        check("t1_ret_pc", 32'(bus_if.ret_pc), 32'h0000E100);
        check("t1_err", 32'(bus_if.err), 32'd0);
        check("t1_irq_pulses", 32'(irq_cnt - irq0), 32'd1);
        check("t1_all_pulses", 32'(all_cnt - all0), 32'd1);

        // Nesting of three, then three RETIs eight cycles apart.
        irq0 = irq_cnt; all0 = all_cnt;
        drive(14'h0001, 1'b0, 16'h0);
        drive(14'h0100, 1'b0, 16'h0);
        drive(14'h2000, 1'b0, 16'h0);
        check("t2_depth3", 32'(bus_if.depth), 32'd3);
        for (int k = 0; k < 3; k++) begin
            drive(14'h0, 1'b1, 16'h0);
            idle(3);
            drive(14'h0, 1'b0, 16'(16'hA000 + k));
            idle(3);
        end
        idle(2);
        check("t2_depth0", 32'(bus_if.depth), 32'd0);
        check("t2_irq_pulses", 32'(irq_cnt - irq0), 32'd3);
        check("t2_all_pulses", 32'(all_cnt - all0), 32'd1);
        check("t2_ret_pc", 32'(bus_if.ret_pc), 32'h0000A002);

        // RETI with nothing open.
        do_reset();
        irq0 = irq_cnt;
        drive(14'h0, 1'b1, 16'h0);
        idle(8);
        check("t3_err", 32'(bus_if.err), 32'b001);
        check("t3_depth", 32'(bus_if.depth), 32'd0);
        check("t3_irq_pulses", 32'(irq_cnt - irq0), 32'd0);

        // Sixteen back-to-back entries saturate the depth.
        do_reset();
        for (int k = 0; k < 16; k++) drive(14'h0010, 1'b0, 16'h0);
        check("t4_depth", 32'(bus_if.depth), 32'd15);
        check("t4_err", 32'(bus_if.err), 32'b010);
        check("t4_in_isr", 32'(bus_if.in_isr), 32'd1);

        // Overlapping RETI and an entry during the in-flight return.
        do_reset();
        drive(14'h0002, 1'b0, 16'h0);
        irq0 = irq_cnt; all0 = all_cnt;
        drive(14'h0, 1'b1, 16'h0);
        drive(14'h0, 1'b0, 16'h0);
        drive(14'h0, 1'b1, 16'h0);
        drive(14'h0800, 1'b0, 16'h0);
        drive(14'h0, 1'b0, 16'h1234);
        check("t5_ret_c5", 32'(bus_if.irq_ret), 32'd1);
        idle(4);
        check("t5_err", 32'(bus_if.err), 32'b100);
        check("t5_depth", 32'(bus_if.depth), 32'd1);
        check("t5_irq_pulses", 32'(irq_cnt - irq0), 32'd1);
        check("t5_all_pulses", 32'(all_cnt - all0), 32'd0);
        check("t5_ret_pc", 32'(bus_if.ret_pc), 32'h00001234);

        // Reset in cycle 3 of WAIT.
        irq0 = irq_cnt;
        drive(14'h0, 1'b1, 16'h5555);
        idle(2);
        rst_n = 1'b0;
        #1;
        check("t6_irq_ret", 32'(bus_if.irq_ret), 32'd0);
        check("t6_depth", 32'(bus_if.depth), 32'd0);
        check("t6_in_isr", 32'(bus_if.in_isr), 32'd0);
        check("t6_err", 32'(bus_if.err), 32'd0);
        check("t6_ret_pc", 32'(bus_if.ret_pc), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(12);
        check("t6_irq_pulses", 32'(irq_cnt - irq0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reti_monitor.md
# reti_monitor

Return-side companion to the interrupt-entry monitor in the hardware-monitor tree. It tracks interrupt nesting from the CPU's interrupt-accept vector and the decoder's RETI-executed strobe. After a fixed pipeline delay it pulses `irq_ret` once the RETI has restored PC and SR, and captures the resumed PC for the attestation/monitor logic. Protocol violations are flagged with sticky error bits: RETI with no open ISR, nesting overflow, and RETI overlapping an in-flight return.

## Interface
Parameters:
- `RET_DELAY`, 4: cycles between the accepted RETI strobe and the cycle in which `ret_pc` is sampled. Legal range 1..15.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `irq_acc`  input  14  one bit per IRQ vector; any nonzero value in a cycle counts as one interrupt entry.
- `reti_exec`  input  1  single-cycle strobe from the decoder: RETI executed.
- `pc`  input  16  current program counter.
- `irq_ret`  output  1  one-cycle pulse: return from interrupt completed.
- `ret_all`  output  1  one-cycle pulse coincident with `irq_ret` when no ISR remains open.
- `ret_pc`  output  16  PC sampled on return; held until the next return.
- `depth`  output  4  current interrupt nesting depth.
- `in_isr`  output  1  `depth != 0`.
- `err`  output  3  sticky flags: [0] unmatched RETI, [1] depth overflow, [2] overlapping RETI.

## Operation
- Reset values: state IDLE, `cnt` = 0, `depth` = 0, `ret_pc` = 16'h0, `err` = 3'b000. `irq_ret`, `ret_all` and `in_isr` are all 0.
- FSM states: IDLE, WAIT, RET.
  - IDLE → WAIT: on `reti_exec` with `depth != 0`. Sets `cnt` to 1.
  - WAIT: `cnt` increments each cycle. When `cnt == RET_DELAY`, the next edge enters RET and loads `ret_pc <= pc`.
  - RET: `irq_ret` = 1 for exactly this one cycle, then → IDLE with `cnt` = 0.
- Accepted RETI means `reti_exec` in IDLE with `depth != 0`. On acceptance, `depth` decrements.
- `reti_exec` in IDLE with `depth == 0`: sets `err[0]`. No sequence starts and `depth` is unchanged.
- `reti_exec` in WAIT or RET: sets `err[2]` and is otherwise ignored. `depth` is unchanged and the in-flight sequence continues.
- `irq_acc != 0`: `depth` increments. At `depth == 15` it saturates at 15 and sets `err[1]`.
- Nonzero `irq_acc` together with an accepted RETI in the same cycle: `depth` is unchanged and the return sequence launches.
- Nonzero `irq_acc` during WAIT/RET: `depth` increments. The return sequence is not cancelled.
- `ret_all` = `irq_ret` AND `depth == 0` AND `irq_acc == 0`, all evaluated in the RET cycle.
- `in_isr` is combinational from `depth`.
- `err` bits clear only on reset. Bits are set independently and several may be set in the same cycle.
- Reset mid-sequence: asynchronous return to reset values, with no `irq_ret` emitted.

## Timing
- `reti_exec` high in cycle 0 (accepted) gives:
  - `depth` decremented from cycle 1.
  - `cnt` = 1 in cycle 1, reaching `cnt` = `RET_DELAY` in cycle `RET_DELAY`.
  - `irq_ret` high in cycle `RET_DELAY`+1.
- `ret_pc` equals the `pc` value of cycle `RET_DELAY`. It is valid from cycle `RET_DELAY`+1 and held afterwards.
- Default `RET_DELAY` = 4: `irq_ret` fires 5 cycles after the strobe, matching the 4-cycle entry delay plus the registered output.
- `depth` and `err` update on the edge after the triggering input.
- `in_isr` follows `depth` with no additional latency.
- A new RETI can be accepted in the cycle immediately after RET, i.e. back-to-back returns separated by RET_DELAY+2 cycles.
- All outputs are registered except `in_isr`, `irq_ret` and `ret_all`, which decode directly from state/`depth` with no input-to-output path other than `irq_acc` into `ret_all`.

## Test plan
- Single nest, `RET_DELAY`=4: `irq_acc`=14'h0004 at cycle 0, then `reti_exec` at cycle 10, with `pc` = 16'hE100 in cycle 14.
  - Expect `depth` = 1 from cycle 1 and 0 from cycle 11.
  - Expect `irq_ret` = `ret_all` = 1 in cycle 15 only, then `ret_pc` = 16'hE100.
  - `err` stays 0.
- Nesting of 3, then three RETIs spaced 8 cycles: `depth` goes 3→2→1→0. `irq_ret` pulses three times; `ret_all` pulses only on the third.
- `reti_exec` at reset with `depth`=0: `err` = 3'b001. `irq_ret` never asserts and `depth` stays 0.
- 16 consecutive `irq_acc` pulses: `depth` saturates at 15 and `err[1]` = 1.
- Accepted RETI at cycle 0, second `reti_exec` at cycle 2, `irq_acc` at cycle 3:
  - `err[2]` = 1.
  - Single `irq_ret` in cycle 5 with `ret_all` = 0.
  - `depth` back to 1.
- Assert `rst_n` low in cycle 3 of WAIT: all outputs return to reset values immediately, and no `irq_ret` follows the release.
